// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and the instruction-memory FSM state encoding.
package cpu_pkg;

  localparam int unsigned CPU_WORD_W    = 32;
  localparam logic [31:0] CPU_BOOT_ADDR = 32'hFFFF_0000;

  typedef logic [1:0] imem_state_t;

  localparam imem_state_t IMEM_IDLE    = 2'd0;
  localparam imem_state_t IMEM_WAIT    = 2'd1;
  localparam imem_state_t IMEM_RESPOND = 2'd2;

endpackage

// File: rtl/cpu_imem_ram.sv
// Single-read, single-write synchronous RAM; read-first on a same-address collision.
module cpu_imem_ram #(
  parameter int unsigned WORDS = 4096,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(WORDS)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [WORDS];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Non-blocking read sees the pre-write contents, giving read-first behaviour.
  always_ff @(posedge clock) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/cpu_imem.sv
// Instruction-memory responder for the cpui_* fetch bus with a host load port.
// Optional next-word prefetch buffer enabled by defining CPU_IMEM_PREFETCH_EN.
module cpu_imem
  import cpu_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned MEM_WORDS   = 4096,
  parameter logic [31:0] BASE_ADDR   = CPU_BOOT_ADDR,
  parameter logic [31:0] OOR_INSTR   = 32'h0000_0000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cpui_request,
  input  logic [31:0]                  cpui_addr,
  output logic [CPU_WORD_W-1:0]        cpui_rdata,
  output logic                         cpui_ack,
  input  logic                         load_we,
  input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
  input  logic [CPU_WORD_W-1:0]        load_wdata,
  output logic                         range_error,
  output logic                         protocol_error
);

  localparam int unsigned AW   = $clog2(MEM_WORDS);
  localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;
  localparam logic [3:0]  WS4  = 4'(WAIT_STATES);

  imem_state_t           state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [AW-1:0]         word_q, word_d;
  logic                  inrange_q, inrange_d;
  logic                  proto_q, proto_d;
  logic [CPU_WORD_W-1:0] hold_q;

  logic [31:0]           offset;
  logic                  req_in_range;
  logic [AW-1:0]         req_word;
  logic                  accept;
  logic                  hit;
  logic                  pf_issue;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic [CPU_WORD_W-1:0] ram_rdata;
  logic [CPU_WORD_W-1:0] resp_data;

  // Modulo-2^32 offset: anything below BASE_ADDR wraps high and falls out of range.
  assign offset       = cpui_addr - BASE_ADDR;
  assign req_in_range = {1'b0, offset} < SPAN;
  assign req_word     = offset[AW+1:2];

  assign accept   = cpui_request && ((state_q == IMEM_IDLE) || (state_q == IMEM_RESPOND));
  assign proto_d  = proto_q || (cpui_request && (state_q == IMEM_WAIT));

  assign cpui_ack       = (state_q == IMEM_RESPOND);
  assign range_error    = cpui_ack && !inrange_q;
  assign protocol_error = proto_q;
  assign cpui_rdata     = cpui_ack ? resp_data : hold_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    inrange_d = inrange_q;
    rd_en     = 1'b0;
    rd_addr   = word_q;
    case (state_q)
      IMEM_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = IMEM_RESPOND;
          rd_en   = inrange_q;
        end
      end
      IMEM_RESPOND: begin
        state_d = IMEM_IDLE;
        if (pf_issue) begin
          rd_en   = 1'b1;
          rd_addr = word_q + AW'(1);
        end
      end
      default: state_d = IMEM_IDLE;
    endcase
    if (accept) begin
      word_d    = req_word;
      inrange_d = req_in_range;
      if (hit || (WAIT_STATES == 0)) begin
        state_d = IMEM_RESPOND;
        cnt_d   = 4'd0;
        if (!hit) begin
          rd_en   = req_in_range;
          rd_addr = req_word;
        end
      end else begin
        state_d = IMEM_WAIT;
        cnt_d   = WS4;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IMEM_IDLE;
      cnt_q     <= 4'd0;
      word_q    <= '0;
      inrange_q <= 1'b0;
      proto_q   <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      inrange_q <= inrange_d;
      proto_q   <= proto_d;
      hold_q    <= cpui_rdata;
    end
  end

`ifdef CPU_IMEM_PREFETCH_EN
  logic                  pf_valid_q, pf_valid_d;
  logic                  pf_fill_q, pf_fill_d;
  logic                  hit_q, hit_d;
  logic [AW-1:0]         pf_addr_q, pf_addr_d;
  logic [CPU_WORD_W-1:0] pf_data_q, pf_data_d;
  logic                  load_hits_pf;

  assign load_hits_pf = load_we && (load_addr == pf_addr_q);
  // A fill still in flight counts as a hit: its data lands before the ack cycle.
  assign hit = (pf_valid_q || pf_fill_q) && req_in_range && (req_word == pf_addr_q) &&
               !load_hits_pf;
  // Prefetch only when the read port is idle and the next word exists and is not being written.
  assign pf_issue = cpui_ack && inrange_q && !accept && (word_q != AW'(MEM_WORDS - 1)) &&
                    !(load_we && (load_addr == word_q + AW'(1)));
  assign resp_data = hit_q ? pf_data_q : (inrange_q ? ram_rdata : OOR_INSTR);

  always_comb begin
    pf_valid_d = pf_valid_q;
    pf_data_d  = pf_data_q;
    pf_addr_d  = pf_addr_q;
    pf_fill_d  = 1'b0;
    hit_d      = accept ? hit : hit_q;
    if (pf_fill_q) begin
      pf_valid_d = 1'b1;
      pf_data_d  = ram_rdata;
    end
    if (load_hits_pf || (accept && !hit)) begin
      pf_valid_d = 1'b0;
    end
    if (pf_issue) begin
      pf_valid_d = 1'b0;
      pf_fill_d  = 1'b1;
      pf_addr_d  = word_q + AW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pf_valid_q <= 1'b0;
      pf_fill_q  <= 1'b0;
      hit_q      <= 1'b0;
      pf_addr_q  <= '0;
      pf_data_q  <= '0;
    end else begin
      pf_valid_q <= pf_valid_d;
      pf_fill_q  <= pf_fill_d;
      hit_q      <= hit_d;
      pf_addr_q  <= pf_addr_d;
      pf_data_q  <= pf_data_d;
    end
  end
`else
  assign hit       = 1'b0;
  assign pf_issue  = 1'b0;
  assign resp_data = inrange_q ? ram_rdata : OOR_INSTR;
`endif

  cpu_imem_ram #(
    .WORDS (MEM_WORDS),
    .WIDTH (CPU_WORD_W)
  ) u_ram (
    .clock (clock),
    .we    (load_we),
    .waddr (load_addr),
    .wdata (load_wdata),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_cpu_imem.sv
// Directed bench for cpu_imem: WAIT_STATES=1 and 0 instances, plus a prefetch instance.
module tb_cpu_imem;

  logic        clock;
  logic        reset;
  logic        load_we;
  logic [11:0] load_addr;
  logic [31:0] load_wdata;

  logic        req1, ack1, rerr1, perr1;
  logic [31:0] addr1, rdata1;
  logic        req0, ack0, rerr0, perr0;
  logic [31:0] addr0, rdata0;

  int tests;
  int fails;

  cpu_imem #(
    .WAIT_STATES (1),
    .MEM_WORDS   (4096),
    .BASE_ADDR   (32'hFFFF_0000),
    .OOR_INSTR   (32'h0010_0073)
  ) dut1 (
    .clock          (clock),
    .reset          (reset),
    .cpui_request   (req1),
    .cpui_addr      (addr1),
    .cpui_rdata     (rdata1),
    .cpui_ack       (ack1),
    .load_we        (load_we),
    .load_addr      (load_addr),
    .load_wdata     (load_wdata),
    .range_error    (rerr1),
    .protocol_error (perr1)
  );

  cpu_imem #(
    .WAIT_STATES (0)
  ) dut0 (
    .clock          (clock),
    .reset          (reset),
    .cpui_request   (req0),
    .cpui_addr      (addr0),
    .cpui_rdata     (rdata0),
    .cpui_ack       (ack0),
    .load_we        (load_we),
    .load_addr      (load_addr),
    .load_wdata     (load_wdata),
    .range_error    (rerr0),
    .protocol_error (perr0)
  );

`ifdef CPU_IMEM_PREFETCH_EN
  logic        reqp, ackp, rerrp, perrp;
  logic [31:0] addrp, rdatap;

  cpu_imem #(
    .WAIT_STATES (3)
  ) dutp (
    .clock          (clock),
    .reset          (reset),
    .cpui_request   (reqp),
    .cpui_addr      (addrp),
    .cpui_rdata     (rdatap),
    .cpui_ack       (ackp),
    .load_we        (load_we),
    .load_addr      (load_addr),
    .load_wdata     (load_wdata),
    .range_error    (rerrp),
    .protocol_error (perrp)
  );
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [11:0] a, input logic [31:0] d);
    load_we    = 1'b1;
    load_addr  = a;
    load_wdata = d;
    tick();
    load_we    = 1'b0;
  endtask

  // One isolated fetch on the WAIT_STATES=1 instance: ack exactly two edges after request.
  task automatic fetch1(input logic [31:0] a, input logic [31:0] d, input logic re,
                        input string tag);
    req1  = 1'b1;
    addr1 = a;
    tick();
    req1  = 1'b0;
    chk({tag, "_early"}, 32'(ack1), 32'd0);
    tick();
    chk({tag, "_ack"}, 32'(ack1), 32'd1);
    chk({tag, "_data"}, rdata1, d);
    chk({tag, "_rerr"}, 32'(rerr1), 32'(re));
    tick();
    chk({tag, "_one_ack"}, 32'(ack1), 32'd0);
    chk({tag, "_held"}, rdata1, d);
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    reset      = 1'b0;
    load_we    = 1'b0;
    load_addr  = '0;
    load_wdata = '0;
    req1 = 1'b0; addr1 = '0;
    req0 = 1'b0; addr0 = '0;
`ifdef CPU_IMEM_PREFETCH_EN
    reqp = 1'b0; addrp = '0;
`endif
    tick();
    tick();
    chk("rst_ack", 32'(ack1), 32'd0);
    chk("rst_rdata", rdata1, 32'd0);
    chk("rst_rerr", 32'(rerr1), 32'd0);
    chk("rst_perr", 32'(perr1), 32'd0);
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    reset = 1'b1;

    load(12'd0, 32'h0000_0013);
    load(12'd1, 32'h0010_0093);
    load(12'd2, 32'h0020_0113);
    load(12'd4095, 32'hDEAD_BEEF);
    tick();

    // Basic fetch with one wait state.
    fetch1(32'hFFFF_0000, 32'h0000_0013, 1'b0, "ws1_word0");

    // Back-to-back fetches with zero wait states: request on every ack cycle.
    req0  = 1'b1;
    addr0 = 32'hFFFF_0000;
    tick();
    chk("b2b_ack0", 32'(ack0), 32'd1);
    chk("b2b_data0", rdata0, 32'h0000_0013);
    addr0 = 32'hFFFF_0004;
    tick();
    chk("b2b_ack1", 32'(ack0), 32'd1);
    chk("b2b_data1", rdata0, 32'h0010_0093);
    addr0 = 32'hFFFF_0008;
    tick();
    chk("b2b_ack2", 32'(ack0), 32'd1);
    chk("b2b_data2", rdata0, 32'h0020_0113);
    req0 = 1'b0;
    tick();
    chk("b2b_end", 32'(ack0), 32'd0);
    chk("b2b_held", rdata0, 32'h0020_0113);
    chk("b2b_noperr", 32'(perr0), 32'd0);

    // Range checks on the WAIT_STATES=1 instance.
    fetch1(32'h0000_1000, 32'h0010_0073, 1'b1, "oor_low");
    fetch1(32'hFFFE_FFFC, 32'h0010_0073, 1'b1, "oor_below_base");
    fetch1(32'hFFFF_0006, 32'h0010_0093, 1'b0, "byte_bits_ignored");
    fetch1(32'hFFFF_3FFC, 32'hDEAD_BEEF, 1'b0, "top_word");
    fetch1(32'hFFFF_4000, 32'h0010_0073, 1'b1, "oor_above_top");

    // Load to the word being read in the same cycle returns the old value.
    req1  = 1'b1;
    addr1 = 32'hFFFF_0008;
    tick();
    req1       = 1'b0;
    load_we    = 1'b1;
    load_addr  = 12'd2;
    load_wdata = 32'hCAFE_F00D;
    chk("rf_early", 32'(ack1), 32'd0);
    tick();
    load_we = 1'b0;
    chk("rf_ack", 32'(ack1), 32'd1);
    chk("rf_old_data", rdata1, 32'h0020_0113);
    tick();
    fetch1(32'hFFFF_0008, 32'hCAFE_F00D, 1'b0, "rf_new");

    // Second request while waiting: ignored, sticky protocol error.
    req1  = 1'b1;
    addr1 = 32'hFFFF_0004;
    tick();
    addr1 = 32'hFFFF_0000;
    chk("pe_before", 32'(perr1), 32'd0);
    tick();
    req1 = 1'b0;
    chk("pe_ack", 32'(ack1), 32'd1);
    chk("pe_data", rdata1, 32'h0010_0093);
    chk("pe_set", 32'(perr1), 32'd1);
    tick();
    chk("pe_no_2nd_ack_a", 32'(ack1), 32'd0);
    tick();
    chk("pe_no_2nd_ack_b", 32'(ack1), 32'd0);
    chk("pe_sticky", 32'(perr1), 32'd1);

    // Reset while a fetch is in WAIT drops it.
    req1  = 1'b1;
    addr1 = 32'hFFFF_0000;
    tick();
    req1  = 1'b0;
    reset = 1'b0;
    tick();
    chk("rw_ack", 32'(ack1), 32'd0);
    chk("rw_perr_clr", 32'(perr1), 32'd0);
    chk("rw_rdata", rdata1, 32'd0);
    reset = 1'b1;
    tick();
    chk("rw_ack_after_a", 32'(ack1), 32'd0);
    tick();
    chk("rw_ack_after_b", 32'(ack1), 32'd0);
    fetch1(32'hFFFF_0000, 32'h0000_0013, 1'b0, "rw_refetch");

    // Default OOR_INSTR on the zero-wait instance.
    req0  = 1'b1;
    addr0 = 32'h0000_1000;
    tick();
    req0 = 1'b0;
    chk("oor0_ack", 32'(ack0), 32'd1);
    chk("oor0_data", rdata0, 32'd0);
    chk("oor0_rerr", 32'(rerr0), 32'd1);
    tick();
    chk("oor0_rerr_pulse", 32'(rerr0), 32'd0);

`ifdef CPU_IMEM_PREFETCH_EN
    // Miss with three wait states, then a prefetched next-word hit.
    reqp  = 1'b1;
    addrp = 32'hFFFF_0000;
    tick();
    reqp = 1'b0;
    chk("pf_miss_w1", 32'(ackp), 32'd0);
    tick();
    chk("pf_miss_w2", 32'(ackp), 32'd0);
    tick();
    chk("pf_miss_w3", 32'(ackp), 32'd0);
    tick();
    chk("pf_miss_ack", 32'(ackp), 32'd1);
    chk("pf_miss_data", rdatap, 32'h0000_0013);
    tick();
    reqp  = 1'b1;
    addrp = 32'hFFFF_0004;
    tick();
    reqp = 1'b0;
    chk("pf_hit_ack", 32'(ackp), 32'd1);
    chk("pf_hit_data", rdatap, 32'h0010_0093);
    reqp  = 1'b0;
    // Refetch word 0, then overwrite word 1 before requesting it.
    reqp  = 1'b1;
    addrp = 32'hFFFF_0000;
    tick();
    reqp = 1'b0;
    tick();
    tick();
    chk("pf_re0_w3", 32'(ackp), 32'd0);
    tick();
    chk("pf_re0_ack", 32'(ackp), 32'd1);
    tick();
    load(12'd1, 32'h1234_5678);
    reqp  = 1'b1;
    addrp = 32'hFFFF_0004;
    tick();
    reqp = 1'b0;
    chk("pf_inv_no_hit", 32'(ackp), 32'd0);
    tick();
    tick();
    chk("pf_inv_w3", 32'(ackp), 32'd0);
    tick();
    chk("pf_inv_ack", 32'(ackp), 32'd1);
    chk("pf_inv_data", rdatap, 32'h1234_5678);
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
